fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Controls the program counter of the RISC-V core and sequences instruction fetch over a request/ready instruction-memory handshake.
- Owns the PC register and selects its next value: sequential PC+4, branch/jump redirect, or trap vector on a misaligned target.
- Presents each fetched instruction to the decode stage with a valid/ack handshake.
- Supports halt and resume at instruction boundaries for debug and bring-up.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded when a redirect target is misaligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request; held until imem_ready.
- imem_addr  output  32  fetch address; equals pc while imem_req=1.
- imem_ready  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instr/instr_pc valid for decode.
- instr  output  32  held instruction word.
- instr_pc  output  32  address of held instruction.
- instr_ack  input  1  decode consumes instruction (only meaningful while instr_valid=1).
- redirect_valid  input  1  branch/jump taken.
- redirect_target  input  32  new PC.
- halt  input  1  halt request (level).
- resume  input  1  leave HALTED (pulse).
- pc  output  32  current PC register.
- trap  output  1  one-cycle pulse, misaligned redirect.
- halted  output  1  high in HALTED.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_VECTOR, state=BOOT.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, trap=0, halted=0, squash=0.
  - Reset asserted mid-fetch drops imem_req in the same cycle, without waiting for a clock edge.
- States: BOOT, FETCH, ISSUE, HALTED.
- BOOT:
  - One cycle, no request.
  - Next state is HALTED if halt=1, else FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc, both stable until imem_ready.
  - imem_ready with squash=0: instr<=imem_rdata, instr_pc<=pc, state ISSUE. instr_valid rises the next cycle.
  - redirect_valid without imem_ready:
    - The request is not abandoned; the address stays stable.
    - squash<=1 and the target is latched; a later redirect overwrites the latched target.
  - imem_ready with squash=1, or with redirect_valid in the same cycle:
    - The returned data is discarded.
    - pc<=latched target or current redirect_target (current wins); squash<=0.
    - State stays FETCH; the new request appears the next cycle.
- ISSUE:
  - instr_valid=1; instr and instr_pc are held stable until ack.
  - instr_ack without redirect: pc<=pc+4.
  - instr_ack with redirect_valid: pc<=redirect_target.
  - After ack: go to HALTED if halt=1, else FETCH.
  - redirect_valid without ack: instr_valid<=0, pc<=target, state FETCH (instruction flushed).
- HALTED:
  - imem_req=0, instr_valid=0, halted=1.
  - redirect_valid updates pc and the state stays HALTED.
  - resume: go to FETCH at pc. halt=1 in the same cycle as resume takes priority; the state stays HALTED.
- halt never interrupts an outstanding fetch or drops an un-acked instruction.
- Misaligned target (target[1:0]!=0), applied wherever a redirect is taken:
  - pc<=TRAP_VECTOR instead of the target.
  - trap pulses for exactly one cycle, coincident with the pc update.
  - For FETCH squash, misalignment is evaluated on the target actually applied.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Throughput: with zero-wait memory and ack immediately at instr_valid, one instruction every 2 cycles (FETCH, ISSUE).

Test Plan:
- Reset, imem_ready always 1, instr_ack tied high → imem_addr sequence 0x0, 0x4, 0x8, 0xC, 0x10. instr_pc matches each address; instr equals the returned rdata.
- Hold imem_ready low 3 cycles, then pulse redirect_valid=1, target=0x40, on cycle 1 → imem_addr stays 0x0 until ready. Data is discarded and instr_valid stays 0. The next request is at 0x40.
- In ISSUE at pc=0x8, redirect to 0x22 with ack → trap pulses one cycle, pc=0x100, next imem_addr=0x100.
- halt=1 while FETCH waits at 0x4 → fetch completes and the instruction issues. After ack: halted=1, pc=0x8, no imem_req. resume → fetch at 0x8.
- Load pc=0xFFFF_FFFC via redirect, ack with no redirect → pc=0x0000_0000.
- Assert rst mid-FETCH at 0x20 → imem_req and instr_valid go 0 immediately. After release: BOOT, then fetch at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction fetch sequencer for the RISC-V core
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ack,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc,
    output logic        trap,
    output logic        halted
);

    localparam logic [1:0] S_BOOT   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        squash_q, squash_d;
    logic        trap_q, trap_d;
    logic        take;
    logic [31:0] take_tgt;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        tgt_d      = tgt_q;
        squash_d   = squash_q;
        trap_d     = 1'b0;
        take       = 1'b0;
        take_tgt   = redirect_target;
        case (state_q)
            S_BOOT: state_d = halt ? S_HALTED : S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    squash_d = 1'b0;
                    if (redirect_valid) begin
                        take = 1'b1;
                    end else if (squash_q) begin
                        take     = 1'b1;
                        take_tgt = tgt_q;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = S_ISSUE;
                    end
                end else if (redirect_valid) begin
                    // Request stays on the bus; the redirect is applied once it returns
                    squash_d = 1'b1;
                    tgt_d    = redirect_target;
                end
            end
            S_ISSUE: begin
                if (instr_ack) begin
                    if (redirect_valid) take = 1'b1;
                    else                pc_d = pc_q + 32'd4;
                    state_d = halt ? S_HALTED : S_FETCH;
                end else if (redirect_valid) begin
                    take    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                if (redirect_valid) take = 1'b1;
                if (resume && !halt) state_d = S_FETCH;
            end
        endcase
        if (take) begin
            if (take_tgt[1:0] != 2'b00) begin
                pc_d   = TRAP_VECTOR;
                trap_d = 1'b1;
            end else begin
                pc_d = take_tgt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VECTOR;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            tgt_q      <= 32'd0;
            squash_q   <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            tgt_q      <= tgt_d;
            squash_q   <= squash_d;
            trap_q     <= trap_d;
        end
    end

    // Decoded straight from the async-reset state so reset drops them immediately
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_ISSUE);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;
    assign trap        = trap_q;
    assign halted      = (state_q == S_HALTED);

endmodule
